// File: rtl/gate_check_pkg.sv
// Shared types and constants for the 2-input gate truth-table checker.
// Truth tables are indexed by {I1,I2}: bit0 = vector 00 ... bit3 = vector 11.
package gate_check_pkg;

   typedef enum logic [1:0] {
      IDLE,
      SETTLE,
      SAMPLE,
      FINISH
   } state_e;

   localparam int NUM_VECTORS = 4;

   localparam logic [3:0] TT_NOR  = 4'b0001;
   localparam logic [3:0] TT_OR   = 4'b1110;
   localparam logic [3:0] TT_AND  = 4'b1000;
   localparam logic [3:0] TT_NAND = 4'b0111;
   localparam logic [3:0] TT_XOR  = 4'b0110;
   localparam logic [3:0] TT_XNOR = 4'b1001;

endpackage

// File: rtl/gate_settle_timer.sv
// Loadable down-counter; tc is high while the count sits at zero.
// Load has priority over decrement, and the count stops at zero.
module gate_settle_timer #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         en,
   output logic         tc
);

   logic [W-1:0] count_q;
   logic [W-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (load) begin
         count_d = load_val;
      end else if (en && (count_q != '0)) begin
         count_d = count_q - 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign tc = (count_q == '0);

endmodule

// File: rtl/gate_truth_checker.sv
// Self-test responder: walks a 2-input gate through all four vectors.
// Define GATE_CHECK_SYNC_EN to pass O through a 2-flop synchronizer.
module gate_truth_checker
   import gate_check_pkg::*;
#(
   parameter logic [3:0] TRUTH_TABLE   = TT_NOR,
   parameter int         SETTLE_CYCLES = 2
) (
   input  logic       CLK,
   input  logic       RST_N,
   input  logic       START,
   input  logic       O,
   output logic       I1,
   output logic       I2,
   output logic       BUSY,
   output logic       DONE,
   output logic       PASS,
   output logic [2:0] ERR_CNT,
   output logic [3:0] FAIL_VEC
);

   localparam int TW = 5;

   logic o_cmp;

`ifdef GATE_CHECK_SYNC_EN
   // Two extra settle cycles cover the synchronizer latency.
   localparam int SETTLE_LEN = SETTLE_CYCLES + 2;

   logic o_s1_q, o_s1_d;
   logic o_s2_q, o_s2_d;

   assign o_s1_d = O;
   assign o_s2_d = o_s1_q;

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         o_s1_q <= 1'b0;
         o_s2_q <= 1'b0;
      end else begin
         o_s1_q <= o_s1_d;
         o_s2_q <= o_s2_d;
      end
   end

   assign o_cmp = o_s2_q;
`else
   localparam int SETTLE_LEN = SETTLE_CYCLES;

   assign o_cmp = O;
`endif

   localparam logic [TW-1:0] LOAD_VAL = TW'(SETTLE_LEN - 1);
   localparam logic [1:0]    LAST_IDX = 2'(NUM_VECTORS - 1);

   state_e     state_q, state_d;
   logic [1:0] idx_q, idx_d;
   logic [2:0] err_cnt_q, err_cnt_d;
   logic [3:0] fail_vec_q, fail_vec_d;
   logic       pass_q, pass_d;
   logic       tmr_load;
   logic       tmr_en;
   logic       tmr_tc;

   gate_settle_timer #(
      .W (TW)
   ) u_timer (
      .clk      (CLK),
      .rst_n    (RST_N),
      .load     (tmr_load),
      .load_val (LOAD_VAL),
      .en       (tmr_en),
      .tc       (tmr_tc)
   );

   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      err_cnt_d  = err_cnt_q;
      fail_vec_d = fail_vec_q;
      pass_d     = pass_q;
      tmr_load   = 1'b0;
      tmr_en     = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (START) begin
               state_d    = SETTLE;
               idx_d      = 2'd0;
               err_cnt_d  = 3'd0;
               fail_vec_d = 4'd0;
               pass_d     = 1'b0;
               tmr_load   = 1'b1;
            end
         end
         SETTLE: begin
            if (tmr_tc) begin
               state_d = SAMPLE;
            end else begin
               tmr_en = 1'b1;
            end
         end
         SAMPLE: begin
            if (o_cmp != TRUTH_TABLE[idx_q]) begin
               err_cnt_d         = err_cnt_q + 3'd1;
               fail_vec_d[idx_q] = 1'b1;
            end
            if (idx_q == LAST_IDX) begin
               state_d = FINISH;
               // Include this vector's result in the verdict.
               pass_d  = (err_cnt_d == 3'd0);
            end else begin
               state_d  = SETTLE;
               idx_d    = idx_q + 2'd1;
               tmr_load = 1'b1;
            end
         end
         FINISH: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q    <= IDLE;
         idx_q      <= 2'd0;
         err_cnt_q  <= 3'd0;
         fail_vec_q <= 4'd0;
         pass_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         err_cnt_q  <= err_cnt_d;
         fail_vec_q <= fail_vec_d;
         pass_q     <= pass_d;
      end
   end

   logic drive_vec;

   assign drive_vec = (state_q == SETTLE) || (state_q == SAMPLE);
   assign {I1, I2}  = drive_vec ? idx_q : 2'b00;
   assign BUSY      = (state_q != IDLE);
   assign DONE      = (state_q == FINISH);
   assign PASS      = pass_q;
   assign ERR_CNT   = err_cnt_q;
   assign FAIL_VEC  = fail_vec_q;

endmodule

// File: tb/tb_gate_truth_checker.sv
// Randomized bench: a modelled gate of random truth table under a NOR checker.
// Expected results come from the bit difference of the two truth tables.
module tb_gate_truth_checker;
   import gate_check_pkg::*;

   localparam logic [3:0] TT = TT_NOR;
   localparam int         SC = 2;
`ifdef GATE_CHECK_SYNC_EN
   localparam int HOLD = SC + 3;
`else
   localparam int HOLD = SC + 1;
`endif
   localparam int L = 4 * HOLD;

   logic       CLK;
   logic       RST_N;
   logic       START;
   logic       O;
   logic       I1, I2;
   logic       BUSY, DONE, PASS;
   logic [2:0] ERR_CNT;
   logic [3:0] FAIL_VEC;
   logic [3:0] act_tt;

   int n_tests = 0;
   int n_fail  = 0;

   gate_truth_checker #(
      .TRUTH_TABLE   (TT),
      .SETTLE_CYCLES (SC)
   ) dut (
      .CLK      (CLK),
      .RST_N    (RST_N),
      .START    (START),
      .O        (O),
      .I1       (I1),
      .I2       (I2),
      .BUSY     (BUSY),
      .DONE     (DONE),
      .PASS     (PASS),
      .ERR_CNT  (ERR_CNT),
      .FAIL_VEC (FAIL_VEC)
   );

   // Gate under test: purely combinational lookup.
   assign O = act_tt[{I1, I2}];

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_vec"},  32'({I1, I2}), 32'd0);
      check({tag, "_busy"}, 32'(BUSY), 32'd0);
      check({tag, "_done"}, 32'(DONE), 32'd0);
      check({tag, "_pass"}, 32'(PASS), 32'd0);
      check({tag, "_err"},  32'(ERR_CNT), 32'd0);
      check({tag, "_fv"},   32'(FAIL_VEC), 32'd0);
   endtask

   // One full run; poke pulses START at edges 3 and L while busy.
   task automatic run(input logic [3:0] act, input bit poke,
                      input bit hold_start);
      logic [3:0] fv;
      int         err;
      fv  = act ^ TT;
      err = $countones(fv);
      act_tt = act;
      @(negedge CLK);
      START = 1'b1;
      @(posedge CLK);
      #1;
      for (int j = 0; j <= L; j++) begin
         check("vec",  32'({I1, I2}), (j < L) ? 32'(j / HOLD) : 32'd0);
         check("busy", 32'(BUSY), 32'd1);
         check("done", 32'(DONE), (j == L) ? 32'd1 : 32'd0);
         if (j == 0) begin
            check("clr_err",  32'(ERR_CNT), 32'd0);
            check("clr_fv",   32'(FAIL_VEC), 32'd0);
            check("clr_pass", 32'(PASS), 32'd0);
         end
         if (j == L) begin
            check("err",  32'(ERR_CNT), 32'(err));
            check("fv",   32'(FAIL_VEC), 32'(fv));
            check("pass", 32'(PASS), (err == 0) ? 32'd1 : 32'd0);
         end
         if (!hold_start) begin
            START = poke && ((j + 1 == 3) || (j + 1 == L));
         end
         @(posedge CLK);
         #1;
      end
      check("idle_busy", 32'(BUSY), 32'd0);
      check("idle_done", 32'(DONE), 32'd0);
      check("hold_err",  32'(ERR_CNT), 32'(err));
      check("hold_fv",   32'(FAIL_VEC), 32'(fv));
      check("hold_pass", 32'(PASS), (err == 0) ? 32'd1 : 32'd0);
      if (!hold_start) begin
         @(posedge CLK);
         #1;
         check("no_rerun", 32'(BUSY), 32'd0);
         check("hold2_err", 32'(ERR_CNT), 32'(err));
      end
   endtask

   initial begin
      int seen;
      RST_N  = 1'b0;
      START  = 1'b0;
      act_tt = TT_NOR;
      #1;
      check_reset_vals("rst");
      @(negedge CLK);
      @(negedge CLK);
      RST_N = 1'b1;

      run(TT_NOR, 1'b0, 1'b0);
      run(4'b0000, 1'b0, 1'b0);
      run(TT_OR, 1'b0, 1'b0);
      run(TT_NOR, 1'b1, 1'b0);
      for (int r = 0; r < 8; r++) begin
         run(4'($urandom_range(15)), 1'($urandom_range(1)), 1'b0);
      end

      // START held high: re-accept one IDLE cycle after FINISH.
      run(TT_OR, 1'b0, 1'b1);
      @(posedge CLK);
      #1;
      check("rerun_busy", 32'(BUSY), 32'd1);
      check("rerun_err",  32'(ERR_CNT), 32'd0);
      check("rerun_fv",   32'(FAIL_VEC), 32'd0);
      START = 1'b0;
      repeat (L) @(posedge CLK);
      #1;
      check("rerun_done", 32'(DONE), 32'd1);
      check("rerun_errf", 32'(ERR_CNT), 32'd4);
      @(posedge CLK);
      #1;

      // Asynchronous reset mid-run after errors have accumulated.
      act_tt = TT_OR;
      @(negedge CLK);
      START = 1'b1;
      @(posedge CLK);
      #1;
      START = 1'b0;
      repeat (6) @(posedge CLK);
      #2;
      check("pre_rst_err", 32'(ERR_CNT != 3'd0), 32'd1);
      RST_N = 1'b0;
      #1;
      check_reset_vals("midrst");
      seen = 0;
      for (int k = 0; k < 2 * L; k++) begin
         @(negedge CLK);
         if (k == 3) RST_N = 1'b1;
         if (DONE) seen++;
      end
      check("rst_nodone", 32'(seen), 32'd0);
      check("rst_idle",   32'(BUSY), 32'd0);
      run(TT_NOR, 1'b0, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout got=%0d exp=%0d", 0, 1);
      $fatal(1, "timeout");
   end

endmodule
